// File: rtl/bus_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_arb_pkg
// Purpose  : Shared state encoding, master indices and defaults for bus_arbiter.
// Revision : 1.0
// ============================================================================
package bus_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_e;

    localparam int unsigned MASTER_CPU       = 0;
    localparam int unsigned MASTER_DMA       = 1;
    localparam int unsigned DEFAULT_MAX_BURST = 4;

endpackage : bus_arb_pkg
`default_nettype wire

// File: rtl/bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter_if
// Purpose  : Two-master request/grant bus plus the bridge side of the arbiter.
// Revision : 1.0
// ============================================================================
interface bus_arbiter_if;

    logic        m0_req;
    logic        m0_lock;
    logic [31:0] m0_addr;
    logic        m0_wen;
    logic [31:0] m0_wdata;
    logic        m0_gnt;

    logic        m1_req;
    logic        m1_lock;
    logic [31:0] m1_addr;
    logic        m1_wen;
    logic [31:0] m1_wdata;
    logic        m1_gnt;

    logic [31:0] m_rdata;

    logic [31:0] Bus_addr;
    logic        Bus_wen;
    logic [31:0] Bus_wdata;
    logic [31:0] Bus_rdata;

    logic [1:0]  arb_owner;

    // Requesting masters and the bridge
    modport master (
        output m0_req, m0_lock, m0_addr, m0_wen, m0_wdata,
        output m1_req, m1_lock, m1_addr, m1_wen, m1_wdata,
        output Bus_rdata,
        input  m0_gnt, m1_gnt, m_rdata,
        input  Bus_addr, Bus_wen, Bus_wdata, arb_owner
    );

    // Arbiter side
    modport slave (
        input  m0_req, m0_lock, m0_addr, m0_wen, m0_wdata,
        input  m1_req, m1_lock, m1_addr, m1_wen, m1_wdata,
        input  Bus_rdata,
        output m0_gnt, m1_gnt, m_rdata,
        output Bus_addr, Bus_wen, Bus_wdata, arb_owner
    );

endinterface : bus_arbiter_if
`default_nettype wire

// File: rtl/arb_pick.sv
`default_nettype none
// ============================================================================
// Module   : arb_pick
// Purpose  : Combinational 2-way picker; round-robin when ARB_ROUND_ROBIN_EN
//            is defined, fixed priority (m0 first) otherwise.
// Revision : 1.0
// ============================================================================
module arb_pick (
    input  wire logic [1:0] req,
    input  wire logic       last_served,
    output logic      [1:0] gnt
);

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        gnt = req;
        // On a tie the master that was not served last goes first
        if (req == 2'b11) begin
            gnt = last_served ? 2'b01 : 2'b10;
        end
    end
`else
    logic w_unused_last_served;
    assign w_unused_last_served = last_served;

    always_comb begin
        gnt = {req[1] & ~req[0], req[0]};
    end
`endif

endmodule : arb_pick
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter
// Purpose  : Two-master single-beat bus arbiter with bounded locked bursts.
//            Define ARB_ROUND_ROBIN_EN for round-robin; fixed priority otherwise.
// Revision : 1.0
// ============================================================================
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
    input  wire logic    cpu_clk,
    input  wire logic    cpu_rst,
    bus_arbiter_if.slave bus
);

    localparam logic [1:0] S_IDLE = 2'(ARB_IDLE);
    localparam logic [1:0] S_OWN0 = 2'(ARB_OWN0);
    localparam logic [1:0] S_OWN1 = 2'(ARB_OWN1);
    localparam logic [3:0] C_MAX_BURST = 4'(MAX_BURST);

    logic [1:0] r_state;
    logic [3:0] r_beat_cnt;
    logic       r_last_served;

    logic [1:0] w_req;
    logic [1:0] w_pick_gnt;
    logic [1:0] w_gnt;
    logic       w_hold0;
    logic       w_hold1;
    logic [1:0] w_state_nxt;
    logic [3:0] w_cnt_nxt;
    logic       w_last_nxt;

    assign w_req = {bus.m1_req, bus.m0_req};

    // The current owner keeps the bus while it still requests and has budget left
    assign w_hold0 = (r_state == S_OWN0) && bus.m0_req && (r_beat_cnt < C_MAX_BURST);
    assign w_hold1 = (r_state == S_OWN1) && bus.m1_req && (r_beat_cnt < C_MAX_BURST);

    arb_pick u_arb_pick (
        .req         (w_req),
        .last_served (r_last_served),
        .gnt         (w_pick_gnt)
    );

    always_comb begin
        w_gnt = w_pick_gnt;
        if (cpu_rst) begin
            w_gnt = 2'b00;
        end else if (w_hold0) begin
            w_gnt = 2'b01;
        end else if (w_hold1) begin
            w_gnt = 2'b10;
        end
    end

    always_comb begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
        w_last_nxt  = r_last_served;
        if (w_gnt[0]) begin
            w_last_nxt = 1'b0;
            if (bus.m0_lock) begin
                w_state_nxt = S_OWN0;
                w_cnt_nxt   = ((r_state == S_OWN0) && (r_beat_cnt < C_MAX_BURST))
                              ? r_beat_cnt + 4'd1 : 4'd1;
            end
        end else if (w_gnt[1]) begin
            w_last_nxt = 1'b1;
            if (bus.m1_lock) begin
                w_state_nxt = S_OWN1;
                w_cnt_nxt   = ((r_state == S_OWN1) && (r_beat_cnt < C_MAX_BURST))
                              ? r_beat_cnt + 4'd1 : 4'd1;
            end
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            r_state       <= S_IDLE;
            r_beat_cnt    <= 4'd0;
            r_last_served <= 1'b1;
        end else begin
            r_state       <= w_state_nxt;
            r_beat_cnt    <= w_cnt_nxt;
            r_last_served <= w_last_nxt;
        end
    end

    always_comb begin
        bus.Bus_addr  = 32'd0;
        bus.Bus_wen   = 1'b0;
        bus.Bus_wdata = 32'd0;
        if (w_gnt[0]) begin
            bus.Bus_addr  = bus.m0_addr;
            bus.Bus_wen   = bus.m0_wen;
            bus.Bus_wdata = bus.m0_wdata;
        end else if (w_gnt[1]) begin
            bus.Bus_addr  = bus.m1_addr;
            bus.Bus_wen   = bus.m1_wen;
            bus.Bus_wdata = bus.m1_wdata;
        end
    end

    assign bus.m0_gnt    = w_gnt[0];
    assign bus.m1_gnt    = w_gnt[1];
    assign bus.m_rdata   = bus.Bus_rdata;
    assign bus.arb_owner = cpu_rst ? S_IDLE : r_state;

    a_gnt_onehot0 : assert property (@(posedge cpu_clk) $onehot0(w_gnt));
    a_gnt_has_req : assert property (@(posedge cpu_clk) (w_gnt & ~w_req) == 2'b00);
    a_wen_no_gnt  : assert property (@(posedge cpu_clk) (w_gnt == 2'b00) |-> !bus.Bus_wen);

endmodule : bus_arbiter
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter
// Purpose  : Self-checking bench for bus_arbiter against an ownership model.
// Revision : 1.0
// ============================================================================
module tb_bus_arbiter;
    import bus_arb_pkg::*;

    localparam int MAXB = 4;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic cpu_clk = 1'b0;
    logic cpu_rst;
    always #5 cpu_clk = ~cpu_clk;

    bus_arbiter_if bif ();

    bus_arbiter #(.MAX_BURST(MAXB)) dut (
        .cpu_clk (cpu_clk),
        .cpu_rst (cpu_rst),
        .bus     (bif)
    );

    int checks = 0;
    int errors = 0;

    // Model: owner -1 = nobody, run = beats in the current locked run
    int m_owner;
    int m_run;
    int m_last;

    function automatic logic [1:0] exp_gnt();
        logic [1:0] r;
        r = {bif.m1_req, bif.m0_req};
        if (m_owner >= 0 && r[m_owner] && m_run < MAXB)
            return (m_owner == 0) ? 2'b01 : 2'b10;
        if (r == 2'b11)
            return (RR && m_last == 0) ? 2'b10 : 2'b01;
        return r;
    endfunction

    function automatic logic [1:0] exp_owner();
        return (m_owner < 0) ? 2'd0 : 2'(m_owner + 1);
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_run   = 0;
        m_last  = 1;
    endtask

    task automatic tick(input logic [1:0] g);
        int  w;
        logic lk;
        if (g == 2'b00) begin
            m_owner = -1;
            m_run   = 0;
        end else begin
            w      = g[1] ? 1 : 0;
            lk     = (w == 1) ? bif.m1_lock : bif.m0_lock;
            m_last = w;
            if (lk) begin
                m_run   = (m_owner == w && m_run < MAXB) ? m_run + 1 : 1;
                m_owner = w;
            end else begin
                m_owner = -1;
                m_run   = 0;
            end
        end
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic drive_idle();
        bif.m0_req = 0; bif.m0_lock = 0; bif.m0_addr = 0; bif.m0_wen = 0; bif.m0_wdata = 0;
        bif.m1_req = 0; bif.m1_lock = 0; bif.m1_addr = 0; bif.m1_wen = 0; bif.m1_wdata = 0;
        bif.Bus_rdata = 0;
    endtask

    task automatic do_reset();
        drive_idle();
        cpu_rst = 1'b1;
        @(posedge cpu_clk);
        #1;
        cpu_rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        cpu_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bif.m0_req = 1'($urandom); bif.m1_req = 1'($urandom);
            bif.m0_lock = 1'b1; bif.m1_lock = 1'b1;
            bif.m0_wen = 1'b1; bif.m1_wen = 1'b1;
            bif.m0_addr = $urandom; bif.m1_addr = $urandom;
            bif.m0_wdata = $urandom; bif.m1_wdata = $urandom;
            @(negedge cpu_clk);
            checks++;
            if ({bif.m1_gnt, bif.m0_gnt} !== 2'b00 || bif.Bus_wen !== 1'b0 ||
                bif.Bus_addr !== 32'd0 || bif.Bus_wdata !== 32'd0 || bif.arb_owner !== 2'd0) begin
                errors++;
                $display("FAIL reset_outputs: gnt=%b wen=%b addr=%h wdata=%h owner=%0d, need all 0",
                         {bif.m1_gnt, bif.m0_gnt}, bif.Bus_wen, bif.Bus_addr, bif.Bus_wdata, bif.arb_owner);
            end
            @(posedge cpu_clk);
            #1;
        end
        cpu_rst = 1'b0;
        drive_idle();
        model_reset();
        @(negedge cpu_clk);
        checks++;
        if (bif.arb_owner !== 2'd0 || {bif.m1_gnt, bif.m0_gnt} !== 2'b00) begin
            errors++;
            $display("FAIL reset_release: owner=%0d gnt=%b, need 0 00", bif.arb_owner, {bif.m1_gnt, bif.m0_gnt});
        end
        tick(2'b00);
    endtask

    task automatic test_single_write();
        do_reset();
        bif.m0_req = 1; bif.m0_addr = 32'h100; bif.m0_wen = 1; bif.m0_wdata = 32'hDEADBEEF;
        @(negedge cpu_clk);
        checks++;
        if ({bif.m1_gnt, bif.m0_gnt} !== 2'b01 || bif.Bus_wen !== 1'b1 ||
            bif.Bus_addr !== 32'h100 || bif.Bus_wdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_write: gnt=%b wen=%b addr=%h wdata=%h, need 01 1 00000100 deadbeef",
                     {bif.m1_gnt, bif.m0_gnt}, bif.Bus_wen, bif.Bus_addr, bif.Bus_wdata);
        end
        tick(2'b01);
        drive_idle();
    endtask

    task automatic test_tie();
        logic [1:0] seq [4];
`ifdef ARB_ROUND_ROBIN_EN
        seq = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        seq = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        do_reset();
        bif.m0_req = 1; bif.m1_req = 1;
        bif.m0_addr = 32'hA0; bif.m1_addr = 32'hB0;
        for (int i = 0; i < 4; i++) begin
            @(negedge cpu_clk);
            checks++;
            if ({bif.m1_gnt, bif.m0_gnt} !== seq[i] || bif.arb_owner !== 2'd0) begin
                errors++;
                $display("FAIL tie_cycle%0d: gnt=%b owner=%0d, need %b 0",
                         i, {bif.m1_gnt, bif.m0_gnt}, bif.arb_owner, seq[i]);
            end
            tick(seq[i]);
        end
        drive_idle();
    endtask

    task automatic test_burst_release();
        logic [1:0] seq [6];
        logic [1:0] e;
`ifdef ARB_ROUND_ROBIN_EN
        seq = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
`else
        seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
`endif
        do_reset();
        bif.m0_req = 1;
        @(negedge cpu_clk);
        tick(2'b01);
        bif.m1_req = 1; bif.m1_lock = 1; bif.m0_lock = 0;
        for (int i = 0; i < 6; i++) begin
            e = exp_gnt();
            @(negedge cpu_clk);
            checks++;
            if ({bif.m1_gnt, bif.m0_gnt} !== seq[i] || {bif.m1_gnt, bif.m0_gnt} !== e ||
                bif.arb_owner !== exp_owner()) begin
                errors++;
                $display("FAIL burst_release_cycle%0d: gnt=%b owner=%0d, need %b %0d",
                         i, {bif.m1_gnt, bif.m0_gnt}, bif.arb_owner, seq[i], exp_owner());
            end
            tick(e);
        end
        drive_idle();
    endtask

    task automatic test_long_burst();
        do_reset();
        bif.m1_req = 1; bif.m1_lock = 1; bif.m1_wen = 1; bif.m1_addr = 32'h2000;
        for (int i = 0; i < 10; i++) begin
            @(negedge cpu_clk);
            checks++;
            if ({bif.m1_gnt, bif.m0_gnt} !== 2'b10 || bif.arb_owner !== exp_owner() ||
                dut.r_beat_cnt !== 4'(m_run) || bif.Bus_wen !== 1'b1) begin
                errors++;
                $display("FAIL long_burst_beat%0d: gnt=%b owner=%0d cnt=%0d wen=%b, need 10 %0d %0d 1",
                         i, {bif.m1_gnt, bif.m0_gnt}, bif.arb_owner, dut.r_beat_cnt, bif.Bus_wen,
                         exp_owner(), m_run);
            end
            tick(2'b10);
        end
        drive_idle();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        bif.m0_req = 1; bif.m0_lock = 1; bif.m0_wen = 1;
        bif.m1_req = 1; bif.m1_lock = 1; bif.m1_wen = 1;
        @(negedge cpu_clk);
        checks++;
        if ({bif.m1_gnt, bif.m0_gnt} !== 2'b01) begin
            errors++;
            $display("FAIL midburst_first_beat: gnt=%b, need 01", {bif.m1_gnt, bif.m0_gnt});
        end
        tick(2'b01);
        cpu_rst = 1'b1;
        @(negedge cpu_clk);
        checks++;
        if ({bif.m1_gnt, bif.m0_gnt} !== 2'b00 || bif.Bus_wen !== 1'b0) begin
            errors++;
            $display("FAIL midburst_in_reset: gnt=%b wen=%b, need 00 0", {bif.m1_gnt, bif.m0_gnt}, bif.Bus_wen);
        end
        @(posedge cpu_clk);
        #1;
        cpu_rst = 1'b0;
        model_reset();
        bif.m0_lock = 0; bif.m1_lock = 0;
        @(negedge cpu_clk);
        checks++;
        if (bif.arb_owner !== 2'd0 || {bif.m1_gnt, bif.m0_gnt} !== 2'b01) begin
            errors++;
            $display("FAIL midburst_after_reset: owner=%0d gnt=%b, need 0 01",
                     bif.arb_owner, {bif.m1_gnt, bif.m0_gnt});
        end
        tick(2'b01);
        drive_idle();
    endtask

    task automatic test_random();
        logic [1:0]  e;
        logic [31:0] ea, ed;
        logic        ew;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bif.Bus_rdata = $urandom;
            e  = exp_gnt();
            ea = e[0] ? bif.m0_addr  : e[1] ? bif.m1_addr  : 32'd0;
            ed = e[0] ? bif.m0_wdata : e[1] ? bif.m1_wdata : 32'd0;
            ew = e[0] ? bif.m0_wen   : e[1] ? bif.m1_wen   : 1'b0;
            @(negedge cpu_clk);
            checks++;
            if ({bif.m1_gnt, bif.m0_gnt} !== e || bif.arb_owner !== exp_owner()) begin
                errors++;
                $display("FAIL random_grant%0d: gnt=%b owner=%0d, need %b %0d",
                         i, {bif.m1_gnt, bif.m0_gnt}, bif.arb_owner, e, exp_owner());
            end
            checks++;
            if (bif.Bus_addr !== ea || bif.Bus_wdata !== ed || bif.Bus_wen !== ew ||
                bif.m_rdata !== bif.Bus_rdata) begin
                errors++;
                $display("FAIL random_bus%0d: addr=%h wdata=%h wen=%b rdata=%h, need %h %h %b %h",
                         i, bif.Bus_addr, bif.Bus_wdata, bif.Bus_wen, bif.m_rdata,
                         ea, ed, ew, bif.Bus_rdata);
            end
            tick(e);
            // A stalled master keeps its request unchanged
            if (!(bif.m0_req && !e[0])) begin
                bif.m0_req = ($urandom_range(0, 9) < 6); bif.m0_lock = 1'($urandom);
                bif.m0_addr = $urandom; bif.m0_wen = 1'($urandom); bif.m0_wdata = $urandom;
            end
            if (!(bif.m1_req && !e[1])) begin
                bif.m1_req = ($urandom_range(0, 9) < 6); bif.m1_lock = 1'($urandom);
                bif.m1_addr = $urandom; bif.m1_wen = 1'($urandom); bif.m1_wdata = $urandom;
            end
        end
        drive_idle();
    endtask

    initial begin
        cpu_rst = 1'b1;
        drive_idle();
        model_reset();
        @(posedge cpu_clk);
        #1;
        test_reset();
        test_single_write();
        test_tie();
        test_burst_release();
        test_long_burst();
        test_reset_mid_burst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_bus_arbiter
`default_nettype wire
